// File: rtl/data_align.sv
// ----------------------------------------------------------------------------
// data_align: store-data lane aligner for the EX/MEM stage.
//
// Takes the store operand (rs2 value) and the byte-write mask from store
// decode and places the low byte / halfword / word into the byte lanes the
// mask selects, so the result can be written straight into data memory.
// Everything is registered with one cycle of latency.
//
// Ports
//   clk         in   1       sole clock, rising edge
//   rst_n       in   1       synchronous active-low reset
//   data_in     in   DATA_W  store operand (byte [7:0], half [15:0], word)
//   MEMWen      in   4       byte-write mask, bit k enables lane k
//   data_out    out  DATA_W  lane-aligned store data, registered
//   MEMWen_out  out  4       registered mask presented to memory
//   align_err   out  1       registered flag: MEMWen was non-canonical
//
// Non-canonical masks produce zero data and a zero mask so that a misaligned
// store becomes a no-op in memory; align_err lets trap/debug logic see it.
// ----------------------------------------------------------------------------
module data_align #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic [3:0]        MEMWen,
    output logic [DATA_W-1:0] data_out,
    output logic [3:0]        MEMWen_out,
    output logic              align_err
);

    localparam int unsigned NumLanes = 4;

    // Decode results for the incoming mask.
    logic       mask_legal;
    logic [1:0] lane_off;   // lowest enabled lane = shift of the operand in bytes

    // Next-state values.
    logic [DATA_W-1:0] data_d;
    logic [3:0]        mask_d;
    logic              err_d;

    // Registered state.
    logic [DATA_W-1:0] data_q;
    logic [3:0]        mask_q;
    logic              err_q;

    // ------------------------------------------------------------------------
    // Mask decode. Only aligned byte, halfword and word masks (plus the empty
    // mask) are legal. For a legal mask the operand's byte 0 lands on the
    // lowest enabled lane, so that lane index is the byte shift.
    // ------------------------------------------------------------------------
    always_comb begin
        mask_legal = 1'b1;
        lane_off   = 2'd0;
        case (MEMWen)
            4'b0000: lane_off = 2'd0;  // no store
            4'b0001: lane_off = 2'd0;
            4'b0010: lane_off = 2'd1;
            4'b0100: lane_off = 2'd2;
            4'b1000: lane_off = 2'd3;
            4'b0011: lane_off = 2'd0;
            4'b1100: lane_off = 2'd2;
            4'b1111: lane_off = 2'd0;
            default: mask_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Lane mux. Lane k takes operand byte (k - lane_off) when enabled; the
    // subtraction never wraps for a legal mask because enabled lanes are at or
    // above lane_off. Disabled lanes and all lanes of an illegal mask are zero.
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < NumLanes; k++) begin : g_lane
        logic [1:0] src;
        assign src = 2'(k) - lane_off;
        assign data_d[8*k +: 8] = (mask_legal && MEMWen[k]) ? data_in[8*src +: 8] : 8'h00;
    end

    always_comb begin
        mask_d = mask_legal ? MEMWen : 4'h0;
        err_d  = ~mask_legal;
    end

    // ------------------------------------------------------------------------
    // Output registers, synchronous reset. The reset cycle's input is dropped.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            mask_q <= 4'h0;
            err_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            mask_q <= mask_d;
            err_q  <= err_d;
        end
    end

    assign data_out   = data_q;
    assign MEMWen_out = mask_q;
    assign align_err  = err_q;

    // ------------------------------------------------------------------------
    // Structural invariants of the registered outputs.
    // ------------------------------------------------------------------------
    // An error always comes with a suppressed write.
    a_err_suppresses : assert property (@(posedge clk) align_err |-> (MEMWen_out == 4'h0 && data_out == '0));

    // Lanes not enabled in the presented mask never carry data.
    for (genvar k = 0; k < NumLanes; k++) begin : g_lane_chk
        a_lane_zero : assert property (@(posedge clk) !MEMWen_out[k] |-> data_out[8*k +: 8] == 8'h00);
    end

endmodule

// File: tb/tb_data_align.sv
// ----------------------------------------------------------------------------
// tb_data_align: scoreboard bench for data_align. The driver applies one
// vector per cycle and queues the expected registered response; the monitor
// pops one entry after every rising edge and compares.
// ----------------------------------------------------------------------------
module tb_data_align;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic [3:0]  MEMWen;
    logic [31:0] data_out;
    logic [3:0]  MEMWen_out;
    logic        align_err;

    data_align #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .MEMWen     (MEMWen),
        .data_out   (data_out),
        .MEMWen_out (MEMWen_out),
        .align_err  (align_err)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  m;
        logic        e;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    stim_done = 1'b0;

    // Hand-computed expected data for a full mask sweep, indexed by MEMWen.
    logic [31:0] tab_1234 [16] = '{
        32'h0000_0000, 32'h0000_0078, 32'h0000_7800, 32'h0000_5678,
        32'h0078_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        32'h7800_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        32'h5678_0000, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678
    };
    logic [31:0] tab_dead [16] = '{
        32'h0000_0000, 32'h0000_00EF, 32'h0000_EF00, 32'h0000_BEEF,
        32'h00EF_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        32'hEF00_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        32'hBEEF_0000, 32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF
    };
    // Legal masks, bit index = MEMWen value: 0,1,2,3,4,8,C,F.
    logic [15:0] legal_set = 16'b1001_0001_0001_1111;

    // Apply one vector for the coming rising edge and queue its response.
    task automatic apply(input logic rst, input logic [31:0] din, input logic [3:0] mw,
                         input logic [31:0] ed, input logic [3:0] em, input logic ee,
                         input string nm);
        exp_t x;
        rst_n   = rst;
        data_in = din;
        MEMWen  = mw;
        x.d = ed;
        x.m = em;
        x.e = ee;
        exp_q.push_back(x);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    // Sweep helper: expected values come from the hand tables above.
    task automatic sweep(input logic [31:0] din, input bit use_dead);
        for (int i = 0; i < 16; i++) begin
            logic [3:0]  mw;
            logic [31:0] ed;
            bit          lg;
            mw = 4'(i);
            ed = use_dead ? tab_dead[i] : tab_1234[i];
            lg = legal_set[i];
            apply(1'b1, din, mw, ed, lg ? mw : 4'h0, ~lg,
                  $sformatf("sweep_%s_m%0h", use_dead ? "dead" : "1234", i));
        end
    endtask

    // Monitor: one response per rising edge, sampled 1 ns after it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                exp_t  x;
                string nm;
                x  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_cmp++;
                if (data_out !== x.d || MEMWen_out !== x.m || align_err !== x.e) begin
                    n_bad++;
                    $display("FAIL %s: got data=%h mask=%h err=%b, expected data=%h mask=%h err=%b",
                             nm, data_out, MEMWen_out, align_err, x.d, x.m, x.e);
                end
                for (int k = 0; k < 4; k++) begin
                    if (!MEMWen_out[k]) begin
                        n_cmp++;
                        if (data_out[8*k +: 8] !== 8'h00) begin
                            n_bad++;
                            $display("FAIL %s lane%0d_zero: got %h, expected 00",
                                     nm, k, data_out[8*k +: 8]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        data_in = 32'h1234_5678;
        MEMWen  = 4'hF;

        // Reset held for two edges, then first live edge.
        apply(1'b0, 32'h1234_5678, 4'hF, 32'h0, 4'h0, 1'b0, "reset_0");
        apply(1'b0, 32'h1234_5678, 4'hF, 32'h0, 4'h0, 1'b0, "reset_1");
        apply(1'b1, 32'h1234_5678, 4'hF, 32'h1234_5678, 4'hF, 1'b0, "first_word");

        // Byte lanes.
        apply(1'b1, 32'h1234_5678, 4'h1, 32'h0000_0078, 4'h1, 1'b0, "byte_l0");
        apply(1'b1, 32'h1234_5678, 4'h2, 32'h0000_7800, 4'h2, 1'b0, "byte_l1");
        apply(1'b1, 32'h1234_5678, 4'h4, 32'h0078_0000, 4'h4, 1'b0, "byte_l2");
        apply(1'b1, 32'h1234_5678, 4'h8, 32'h7800_0000, 4'h8, 1'b0, "byte_l3");

        // Halfword / word / none.
        apply(1'b1, 32'h1234_5678, 4'h3, 32'h0000_5678, 4'h3, 1'b0, "half_lo");
        apply(1'b1, 32'h1234_5678, 4'hC, 32'h5678_0000, 4'hC, 1'b0, "half_hi");
        apply(1'b1, 32'h1234_5678, 4'hF, 32'h1234_5678, 4'hF, 1'b0, "word");
        apply(1'b1, 32'h1234_5678, 4'h0, 32'h0000_0000, 4'h0, 1'b0, "none");

        // Illegal masks.
        apply(1'b1, 32'h1234_5678, 4'h5, 32'h0, 4'h0, 1'b1, "illegal_5");
        apply(1'b1, 32'h1234_5678, 4'h6, 32'h0, 4'h0, 1'b1, "illegal_6");
        apply(1'b1, 32'h1234_5678, 4'h7, 32'h0, 4'h0, 1'b1, "illegal_7");
        apply(1'b1, 32'h1234_5678, 4'h9, 32'h0, 4'h0, 1'b1, "illegal_9");
        apply(1'b1, 32'h1234_5678, 4'hA, 32'h0, 4'h0, 1'b1, "illegal_a");
        apply(1'b1, 32'h1234_5678, 4'hB, 32'h0, 4'h0, 1'b1, "illegal_b");
        apply(1'b1, 32'h1234_5678, 4'hD, 32'h0, 4'h0, 1'b1, "illegal_d");
        apply(1'b1, 32'h1234_5678, 4'hE, 32'h0, 4'h0, 1'b1, "illegal_e");

        // Reset mid-operation drops that cycle's input; recovery is immediate.
        apply(1'b1, 32'h1234_5678, 4'h5, 32'h0, 4'h0, 1'b1, "pre_rst_illegal");
        apply(1'b0, 32'hDEAD_BEEF, 4'hF, 32'h0, 4'h0, 1'b0, "mid_reset");
        apply(1'b1, 32'hDEAD_BEEF, 4'hC, 32'hBEEF_0000, 4'hC, 1'b0, "post_reset");

        // Full sweeps with both operands.
        sweep(32'h1234_5678, 1'b0);
        sweep(32'hDEAD_BEEF, 1'b1);

        stim_done = 1'b1;
    end

    // Drain with a bounded wait, then report.
    initial begin
        wait (stim_done);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending responses, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time guard.
    initial begin
        #20000;
        $display("FAIL timeout: got no finish by 20000 ns, expected completion");
        $fatal(1, "timeout");
    end

endmodule
